// File: rtl/sync_delay_sched.sv
// Timed-event scheduler: holds up to DEPTH tagged strobes, each in its own
// down-counting slot, and emits each strobe with its tag once its delay has
// elapsed. At most one expiry is emitted per clock, lowest slot index first.
module sync_delay_sched #(
    parameter int CNT_W  = 16,
    parameter int TAG_W  = 4,
    parameter int DEPTH  = 4,
    parameter int PEND_W = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              in_stb,
    input  logic [TAG_W-1:0]  in_tag,
    input  logic [CNT_W-1:0]  delay,
    input  logic              clr_ovf,
    output logic              out_stb,
    output logic [TAG_W-1:0]  out_tag,
    output logic [PEND_W-1:0] pending,
    output logic              overflow
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // Slot storage
    logic [DEPTH-1:0] valid_q, valid_d;
    logic [CNT_W-1:0] cnt_q [DEPTH];
    logic [CNT_W-1:0] cnt_d [DEPTH];
    logic [TAG_W-1:0] tag_q [DEPTH];
    logic [TAG_W-1:0] tag_d [DEPTH];

    // Registered outputs
    logic              out_stb_q, out_stb_d;
    logic [TAG_W-1:0]  out_tag_q, out_tag_d;
    logic [PEND_W-1:0] pending_q, pending_d;
    logic              overflow_q, overflow_d;

    // Per-cycle decisions, all taken from the state at the start of the cycle
    logic [DEPTH-1:0] ready;
    logic             free_found, grant_found, drop;
    logic [IDX_W-1:0] free_idx, grant_idx;

    // Slot selection, countdown, allocation and grant for this cycle
    always_comb begin
        // NOTE: every combinational output is given a default first so no path
        // leaves it unassigned; otherwise synthesis infers a latch.
        valid_d     = valid_q;
        cnt_d       = cnt_q;
        tag_d       = tag_q;
        ready       = '0;
        free_found  = 1'b0;
        free_idx    = '0;
        grant_found = 1'b0;
        grant_idx   = '0;

        for (int i = 0; i < DEPTH; i++) begin
            ready[i] = valid_q[i] && (cnt_q[i] == '0);
        end

        // Lowest-index invalid slot is the allocation target
        for (int i = 0; i < DEPTH; i++) begin
            if (!valid_q[i] && !free_found) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
        end

        // Lowest-index ready slot wins the single grant of this cycle
        for (int i = 0; i < DEPTH; i++) begin
            if (enable && ready[i] && !grant_found) begin
                grant_found = 1'b1;
                grant_idx   = IDX_W'(i);
            end
        end

        // Counters saturate at zero; ready slots simply hold there
        if (enable) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (valid_q[i] && (cnt_q[i] != '0)) begin
                    cnt_d[i] = cnt_q[i] - 1'b1;
                end
            end
        end

        if (grant_found) begin
            valid_d[grant_idx] = 1'b0;
        end

        // The free slot was invalid at cycle start, so it never collides with
        // the granted slot, and a slot freed this cycle is not reused yet.
        drop = in_stb && !free_found;
        if (in_stb && free_found) begin
            valid_d[free_idx] = 1'b1;
            cnt_d[free_idx]   = delay;
            tag_d[free_idx]   = in_tag;
        end
    end

    // Output next-state: expiry pulse, held tag, occupancy and sticky overflow
    always_comb begin
        out_stb_d  = grant_found;
        out_tag_d  = grant_found ? tag_q[grant_idx] : out_tag_q;
        overflow_d = drop || (overflow_q && !clr_ovf);
        pending_d  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            pending_d = pending_d + {{(PEND_W-1){1'b0}}, valid_d[i]};
        end
    end

    // Control state and outputs, cleared by synchronous reset
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the pre-edge values, independent of statement order.
        if (reset) begin
            valid_q    <= '0;
            out_stb_q  <= 1'b0;
            out_tag_q  <= '0;
            pending_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            valid_q    <= valid_d;
            out_stb_q  <= out_stb_d;
            out_tag_q  <= out_tag_d;
            pending_q  <= pending_d;
            overflow_q <= overflow_d;
        end
    end

    // Slot payload storage
    always_ff @(posedge clk) begin
        // NOTE: counters and tags are not reset; they are only ever read through
        // a set valid bit, so clearing valid_q is sufficient and keeps this a
        // plain register array.
        cnt_q <= cnt_d;
        tag_q <= tag_d;
    end

    assign out_stb  = out_stb_q;
    assign out_tag  = out_tag_q;
    assign pending  = pending_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_sync_delay_sched.sv
// Self-checking bench for sync_delay_sched. A behavioural model tracks each
// scheduled event as "delay still owed versus enabled cycles already seen" and
// is compared with the DUT every cycle; directed sequences add literal checks.
module tb_sync_delay_sched;

    localparam int CNT_W  = 16;
    localparam int TAG_W  = 4;
    localparam int DEPTH  = 4;
    localparam int PEND_W = $clog2(DEPTH + 1);

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              enable = 1'b0;
    logic              in_stb = 1'b0;
    logic [TAG_W-1:0]  in_tag = '0;
    logic [CNT_W-1:0]  delay = '0;
    logic              clr_ovf = 1'b0;
    logic              out_stb;
    logic [TAG_W-1:0]  out_tag;
    logic [PEND_W-1:0] pending;
    logic              overflow;

    sync_delay_sched #(
        .CNT_W (CNT_W),
        .TAG_W (TAG_W),
        .DEPTH (DEPTH),
        .PEND_W(PEND_W)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .enable  (enable),
        .in_stb  (in_stb),
        .in_tag  (in_tag),
        .delay   (delay),
        .clr_ovf (clr_ovf),
        .out_stb (out_stb),
        .out_tag (out_tag),
        .pending (pending),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: an event is due once it has seen at least 'delay' enabled cycles
    // after the cycle it was accepted in.
    typedef struct {
        bit              busy;
        int unsigned     owed;
        int unsigned     seen;
        logic [TAG_W-1:0] tag;
    } ev_t;

    ev_t              m_slot [DEPTH];
    bit               e_stb;
    logic [TAG_W-1:0] e_tag;
    int               e_pend;
    bit               e_ovf;

    task automatic model_step();
        int g = -1;
        int f = -1;
        bit dropped;
        if (reset) begin
            foreach (m_slot[i]) m_slot[i].busy = 1'b0;
            e_stb = 1'b0; e_tag = '0; e_pend = 0; e_ovf = 1'b0;
            return;
        end
        if (enable) begin
            for (int i = 0; i < DEPTH; i++)
                if (g < 0 && m_slot[i].busy && m_slot[i].seen >= m_slot[i].owed) g = i;
        end
        for (int i = 0; i < DEPTH; i++)
            if (f < 0 && !m_slot[i].busy) f = i;
        if (enable) begin
            for (int i = 0; i < DEPTH; i++)
                if (m_slot[i].busy) m_slot[i].seen++;
        end
        e_stb = (g >= 0);
        if (g >= 0) begin
            e_tag = m_slot[g].tag;
            m_slot[g].busy = 1'b0;
        end
        dropped = in_stb && (f < 0);
        if (in_stb && f >= 0) begin
            m_slot[f].busy = 1'b1;
            m_slot[f].owed = int'(delay);
            m_slot[f].seen = 0;
            m_slot[f].tag  = in_tag;
        end
        e_ovf  = dropped || (e_ovf && !clr_ovf);
        e_pend = 0;
        foreach (m_slot[i]) if (m_slot[i].busy) e_pend++;
    endtask

    // One clock: apply inputs, advance model on the edge, compare 1 time unit later
    task automatic step(input bit rst, input bit stb, input logic [TAG_W-1:0] tg,
                        input logic [CNT_W-1:0] dl, input bit en, input bit clr);
        reset = rst; in_stb = stb; in_tag = tg; delay = dl; enable = en; clr_ovf = clr;
        @(posedge clk);
        model_step();
        #1;
        check("out_stb",  32'(out_stb),  32'(e_stb));
        check("out_tag",  32'(out_tag),  32'(e_tag));
        check("pending",  32'(pending),  32'(e_pend));
        check("overflow", 32'(overflow), 32'(e_ovf));
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, '0, '0, 1'b1, 1'b0);
    endtask

    initial begin
        int c;

        // Reset state
        do_reset();
        do_reset();
        check("rst_out_stb",  32'(out_stb),  32'd0);
        check("rst_out_tag",  32'(out_tag),  32'd0);
        check("rst_pending",  32'(pending),  32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);

        // Single event: strobe in cycle 10, delay 5, tag 3 -> out in cycle 17
        for (int k = 0; k < 20; k++) begin
            step(1'b0, k == 10, 4'd3, 16'd5, 1'b1, 1'b0);
            c = k + 1;
            check("single_stb", 32'(out_stb), 32'(c == 17));
            if (c == 17) check("single_tag", 32'(out_tag), 32'd3);
            check("single_pend", 32'(pending), 32'((c >= 11 && c <= 16) ? 1 : 0));
        end

        // Zero delay back-to-back
        do_reset();
        for (int k = 0; k < 6; k++) begin
            step(1'b0, k < 2, (k == 0) ? 4'd1 : 4'd2, 16'd0, 1'b1, 1'b0);
            c = k + 1;
            check("zero_stb", 32'(out_stb), 32'(c == 2 || c == 3));
            if (c == 2) check("zero_tag1", 32'(out_tag), 32'd1);
            if (c == 3) check("zero_tag2", 32'(out_tag), 32'd2);
        end

        // Out of order completion
        do_reset();
        for (int k = 0; k < 15; k++) begin
            step(1'b0, k < 2, (k == 0) ? 4'hA : 4'hB, (k == 0) ? 16'd10 : 16'd2, 1'b1, 1'b0);
            c = k + 1;
            check("ooo_stb", 32'(out_stb), 32'(c == 5 || c == 12));
            if (c == 5)  check("ooo_tagB", 32'(out_tag), 32'hB);
            if (c == 12) check("ooo_tagA", 32'(out_tag), 32'hA);
        end

        // Contention: both ready in cycle 5, emitted in index order
        do_reset();
        for (int k = 0; k < 10; k++) begin
            step(1'b0, k < 2, (k == 0) ? 4'd5 : 4'd6, (k == 0) ? 16'd4 : 16'd3, 1'b1, 1'b0);
            c = k + 1;
            check("cont_stb", 32'(out_stb), 32'(c == 6 || c == 7));
            if (c == 6) check("cont_tag0", 32'(out_tag), 32'd5);
            if (c == 7) check("cont_tag1", 32'(out_tag), 32'd6);
        end

        // Full / overflow, clear, and clear colliding with a new drop
        do_reset();
        for (int k = 0; k < 5; k++) step(1'b0, 1'b1, 4'(k), 16'd100, 1'b1, 1'b0);
        check("full_ovf",  32'(overflow), 32'd1);
        check("full_pend", 32'(pending),  32'd4);
        step(1'b0, 1'b0, '0, '0, 1'b1, 1'b1);
        check("clr_ovf", 32'(overflow), 32'd0);
        step(1'b0, 1'b1, 4'd9, 16'd1, 1'b1, 1'b1);
        check("set_wins", 32'(overflow), 32'd1);
        check("set_pend", 32'(pending),  32'd4);

        // Freeze: delay 6 at cycle 0, enable low in cycles 3..7 -> out in cycle 13
        do_reset();
        for (int k = 0; k < 18; k++) begin
            step(1'b0, k == 0, 4'd7, 16'd6, !(k >= 3 && k <= 7), 1'b0);
            c = k + 1;
            check("frz_stb", 32'(out_stb), 32'(c == 13));
            if (c == 13) check("frz_tag", 32'(out_tag), 32'd7);
        end

        // Reset at cycle 4 of a delay-20 event discards it
        do_reset();
        for (int k = 0; k < 40; k++) begin
            step(k == 4, k == 0, 4'd8, 16'd20, 1'b1, 1'b0);
            c = k + 1;
            if (c >= 5) begin
                check("mrst_pend", 32'(pending), 32'd0);
                check("mrst_stb",  32'(out_stb), 32'd0);
            end
        end

        // Maximum delay: accepted, no wrap, stays pending
        do_reset();
        step(1'b0, 1'b1, 4'hF, 16'hFFFF, 1'b1, 1'b0);
        for (int k = 0; k < 30; k++) step(1'b0, 1'b0, '0, '0, 1'b1, 1'b0);
        check("max_pend", 32'(pending), 32'd1);
        check("max_stb",  32'(out_stb), 32'd0);

        // Randomized traffic against the model
        do_reset();
        for (int k = 0; k < 3000; k++) begin
            step($urandom_range(0, 299) == 0,
                 $urandom_range(0, 99) < 45,
                 TAG_W'($urandom),
                 ($urandom_range(0, 19) == 0) ? CNT_W'($urandom_range(0, 60))
                                              : CNT_W'($urandom_range(0, 12)),
                 $urandom_range(0, 99) < 85,
                 $urandom_range(0, 99) < 5);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sync_delay_sched.md
Name: sync_delay_sched

Overview:
- Timed-event scheduler for the imitator sync subsystem.
- Accepts sync strobes, each tagged and each with its own delay, and holds up to DEPTH of them at once in independent down-counting slots.
- Emits each strobe with its tag when its delay expires, one per clock. A fixed register delay line cannot do this: it supports only one fixed delay and one event in flight per stage.

Parameters:
CNT_W, 16, width of delay value and slot counters
TAG_W, 4, width of payload tag carried with each strobe
DEPTH, 4, number of scheduler slots (2..16)
PEND_W, $clog2(DEPTH+1), width of pending count

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
enable  input  1  1 = counters run and grants allowed; 0 = freeze
in_stb  input  1  request strobe, one event per high cycle
in_tag  input  TAG_W  tag sampled with in_stb
delay  input  CNT_W  delay in clocks, sampled with in_stb
clr_ovf  input  1  clears overflow flag
out_stb  output  1  one-cycle expiry pulse, registered
out_tag  output  TAG_W  tag of expiring event, valid while out_stb=1
pending  output  PEND_W  number of occupied slots, registered
overflow  output  1  sticky: a strobe was dropped

Behaviour:
- Reset: one clock and reset; reset is synchronous and active-high. When reset=1 at a clock edge:
  - all slots go invalid;
  - out_stb=0, out_tag=0, pending=0, overflow=0.
  - Reset mid-operation discards all slots. No out_stb appears afterwards for pre-reset events.
- Slot state: each slot holds valid, cnt[CNT_W] and tag[TAG_W].
- Allocation:
  - in_stb=1 loads the lowest-index slot that is invalid at the start of the cycle: valid=1, cnt=delay, tag=in_tag.
  - Allocation is independent of enable.
  - A slot freed by a grant in the same cycle is not reusable until the next cycle.
- Full:
  - in_stb=1 with all slots valid at cycle start drops the event and sets overflow=1.
  - This holds even if a grant frees a slot in that cycle.
- Countdown:
  - With enable=1, every valid slot whose cnt>0 at cycle start decrements by 1.
  - A slot loaded this cycle does not decrement this cycle.
- Ready and grant:
  - A slot is ready when valid=1 and cnt==0 at cycle start.
  - With enable=1 and at least one slot ready, the lowest-index ready slot is granted:
    - the slot goes invalid;
    - out_stb=1 and out_tag=its tag on the next cycle.
  - Other ready slots hold at cnt=0 and are granted in later cycles in index order.
  - At most one grant per cycle.
- Outputs otherwise:
  - out_stb=0 in every cycle without a grant.
  - out_tag holds its last value.
- Latency:
  - With no contention, enable=1 and a free slot, in_stb high in cycle n gives out_stb high in cycle n+delay+2.
  - delay=0 gives n+2.
  - delay=2^CNT_W-1 is legal with no wrap: the counter saturates at 0.
- enable=0:
  - counters freeze and no grants occur;
  - out_stb=0 from the following cycle;
  - allocation continues.
  - Re-enabling resumes countdown from the frozen values.
- pending: registered count of valid slots after the cycle's allocation and grant.
- overflow:
  - set by a drop, cleared by clr_ovf;
  - if set and clear occur in the same cycle, set wins.
- Arithmetic: delay is unsigned; a strobe with a delay is an independent event; events may complete out of arrival order.

Test Plan:
- Single event: enable=1, in_stb at cycle 10 with delay=5, tag=3 -> out_stb=1 only in cycle 17, out_tag=3; pending 1 during cycles 11..16, 0 from cycle 17.
- Zero delay plus back-to-back: in_stb in cycles 0 and 1 with delay=0, tags 1,2 -> out_stb in cycles 2 (tag 1) and 3 (tag 2).
- Out of order: in_stb cycle 0 delay=10 tag=A, cycle 1 delay=2 tag=B -> tag B in cycle 5, tag A in cycle 12.
- Contention: in_stb cycle 0 delay=4 (slot 0), cycle 1 delay=3 (slot 1) -> both ready in cycle 5; slot 0 out cycle 6, slot 1 out cycle 7.
- Full/overflow: DEPTH=4, five strobes cycles 0..4 with delay=100 -> fifth dropped, overflow=1, pending=4. clr_ovf pulse -> overflow=0. clr_ovf together with another drop -> overflow stays 1.
- Freeze and reset:
  - delay=6 at cycle 0, enable=0 for cycles 3..7 -> out_stb in cycle 13.
  - Separately, reset at cycle 4 of a delay=20 event -> pending=0 and no out_stb through cycle 40.
